// File: rtl/gpu_hw_regs_pkg.sv
// gpu_hw_regs_pkg
//   Constants and types shared by the read-side (gpu_hw_regs_reader) and the
//   write-side register block: register window geometry, host bus widths and
//   the reader FSM state encoding.
package gpu_hw_regs_pkg;

  localparam int HW_REGS_SIZE = 256;
  localparam int BASE_ADDRESS = 16384 - HW_REGS_SIZE;

  localparam int ADDR_W = 20;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } rd_state_e;

  // Width of a byte offset into a window of `size` bytes (at least 1 bit).
  function automatic int off_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/gpu_hw_regs_bytesel.sv
// gpu_hw_regs_bytesel
//   Purely combinational helper for the register reader.
//   - Window decode of a host address: in-range flag and byte offset.
//   - Byte mux selecting register `sel` from the flat register bank.
// Ports
//   hw_regs   in  flat bank, byte n at [8n+7:8n]
//   addr      in  host byte address to decode
//   sel       in  byte offset to read
//   in_range  out addr lies in [BASE_ADDRESS, BASE_ADDRESS+HW_REGS_SIZE)
//   offset    out addr - BASE_ADDRESS (meaningful only when in_range)
//   byte_data out register byte at offset sel
module gpu_hw_regs_bytesel
  import gpu_hw_regs_pkg::*;
#(
  parameter int HW_REGS_SIZE = gpu_hw_regs_pkg::HW_REGS_SIZE,
  parameter int BASE_ADDRESS = 16384 - HW_REGS_SIZE,
  localparam int OFF_W = off_width(HW_REGS_SIZE)
) (
  input  logic [8*HW_REGS_SIZE-1:0] hw_regs,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [OFF_W-1:0]          sel,
  output logic                      in_range,
  output logic [OFF_W-1:0]          offset,
  output logic [7:0]                byte_data
);

  // One extra bit so BASE_ADDRESS+HW_REGS_SIZE never aliases back to zero.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDRESS);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDRESS + HW_REGS_SIZE);

  logic [ADDR_W:0] addr_ext;

  assign addr_ext = {1'b0, addr};
  assign in_range = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign offset   = OFF_W'(addr_ext - WIN_LO);

  // Compare-based mux so a non-power-of-two window never indexes past the bank.
  always_comb begin
    byte_data = 8'h00;
    for (int i = 0; i < HW_REGS_SIZE; i++) begin
      if (sel == OFF_W'(i)) byte_data = hw_regs[8*i +: 8];
    end
  end

endmodule

// File: rtl/gpu_hw_regs_reader.sv
// gpu_hw_regs_reader
//   Burst reader for a window of byte-wide hardware registers. A host request
//   (start address, length-1) is accepted in IDLE and streamed out one byte
//   per beat on a valid/ready interface. Offsets wrap inside the window; a
//   start address outside the window yields a full-length burst of zero bytes
//   flagged with out_err. Each beat samples hw_regs at the moment it is loaded.
// Ports
//   clk        in  clock, rising edge
//   reset      in  asynchronous reset, active low
//   hw_regs    in  flat register bank, byte n at [8n+7:8n]
//   rd_req     in  read request, taken only in IDLE
//   rd_addr    in  host byte address of the first byte
//   rd_len     in  burst length minus one
//   rd_busy    out a burst is in progress
//   out_valid  out beat on out_data/out_err/out_last is valid
//   out_ready  in  consumer takes the beat when out_valid && out_ready
//   out_data   out register byte
//   out_err    out burst start address was outside the window
//   out_last   out final beat of the burst
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for rd_req; start offset, length and error flag latched
// FETCH | one cycle: first byte registered onto out_data, out_valid raised
// SEND  | beat presented; on handshake load next byte or finish the burst
module gpu_hw_regs_reader
  import gpu_hw_regs_pkg::*;
#(
  parameter int HW_REGS_SIZE = gpu_hw_regs_pkg::HW_REGS_SIZE,
  parameter int BASE_ADDRESS = 16384 - HW_REGS_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*HW_REGS_SIZE-1:0] hw_regs,
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [LEN_W-1:0]          rd_len,
  output logic                      rd_busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_err,
  output logic                      out_last
);

  localparam int OFF_W = off_width(HW_REGS_SIZE);

  rd_state_e        state_q;
  logic [LEN_W-1:0] count_q;
  logic [OFF_W-1:0] offset_q;
  logic             err_q;

  logic [OFF_W-1:0] next_offset;
  logic [OFF_W-1:0] sel;
  logic             dec_in_range;
  logic [OFF_W-1:0] dec_offset;
  logic [7:0]       sel_byte;

  assign next_offset = (offset_q == OFF_W'(HW_REGS_SIZE - 1)) ? '0
                                                             : offset_q + OFF_W'(1);

  // FETCH loads the byte at the current offset; a SEND handshake loads the
  // byte at the offset it is about to advance to.
  assign sel = (state_q == SEND) ? next_offset : offset_q;

  gpu_hw_regs_bytesel #(
    .HW_REGS_SIZE (HW_REGS_SIZE),
    .BASE_ADDRESS (BASE_ADDRESS)
  ) u_bytesel (
    .hw_regs   (hw_regs),
    .addr      (rd_addr),
    .sel       (sel),
    .in_range  (dec_in_range),
    .offset    (dec_offset),
    .byte_data (sel_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      offset_q  <= '0;
      err_q     <= 1'b0;
      rd_busy   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            offset_q <= dec_offset;
            err_q    <= !dec_in_range;
            count_q  <= rd_len;
            rd_busy  <= 1'b1;
            state_q  <= FETCH;
          end
        end

        FETCH: begin
          out_data  <= err_q ? 8'h00 : sel_byte;
          out_err   <= err_q;
          out_last  <= (count_q == '0);
          out_valid <= 1'b1;
          state_q   <= SEND;
        end

        SEND: begin
          if (out_valid && out_ready) begin
            if (count_q == '0) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_busy   <= 1'b0;
              state_q   <= IDLE;
            end else begin
              count_q  <= count_q - LEN_W'(1);
              offset_q <= next_offset;
              out_data <= err_q ? 8'h00 : sel_byte;
              out_last <= (count_q == LEN_W'(1));
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpu_hw_regs_reader.md
GPU_HW_REGS_READER -- requirements
Module: gpu_hw_regs_reader

Interface
REQ-001 Parameter HW_REGS_SIZE, default 256, is the number of byte registers in the window.
REQ-002 Parameter BASE_ADDRESS, default 16384-HW_REGS_SIZE (16128), is the first host address of the window.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 hw_regs  input  8*HW_REGS_SIZE  flat register bank; byte n occupies bits [8n+7:8n].
REQ-006 rd_req  input  1  read request strobe; accepted only when rd_busy=0.
REQ-007 rd_addr  input  20  host byte address of the first byte, sampled on acceptance.
REQ-008 rd_len  input  8  burst length minus one (0 = 1 byte, 255 = 256 bytes), sampled on acceptance.
REQ-009 rd_busy  output  1  high from the edge after acceptance until the last beat handshakes.
REQ-010 out_valid  output  1  out_data, out_err and out_last are valid.
REQ-011 out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high.
REQ-012 out_data  output  8  register byte.
REQ-013 out_err  output  1  burst start address lies outside the window.
REQ-014 out_last  output  1  current beat is the final beat of the burst.

Function
REQ-015 The FSM shall have states IDLE, FETCH and SEND.
REQ-016 IDLE: on rd_req=1, latch rd_addr and rd_len, set rd_busy, and go to FETCH.
REQ-017 FETCH (one cycle): register the byte at the current offset into out_data, set out_valid, and go to SEND.
REQ-018 Latency: a request accepted on edge N gives out_valid=1 from edge N+2.
REQ-019 SEND with out_valid=1 and out_ready=0: all outputs shall hold stable.
REQ-020 SEND handshake with count=0: clear out_valid, out_last and rd_busy, and return to IDLE.
REQ-021 SEND handshake with count>0: decrement count, advance the offset, load the next byte with out_valid held high, giving 1 beat per cycle.
REQ-022 Offset = rd_addr - BASE_ADDRESS; the offset shall wrap from HW_REGS_SIZE-1 to 0 within a burst.
REQ-023 out_last shall equal (count==0) for the beat presented.
REQ-024 Each beat shall sample hw_regs when the beat is loaded; a burst is not a coherent snapshot.
REQ-025 A start address outside [BASE_ADDRESS, BASE_ADDRESS+HW_REGS_SIZE) shall produce the full burst length with out_data=0x00 and out_err=1 on every beat.
REQ-026 rd_req while rd_busy=1 shall be ignored with no side effect.
REQ-027 rd_req asserted in the same cycle as the final handshake shall be ignored; acceptance requires IDLE.

Reset
REQ-028 While reset=0, the block shall immediately and asynchronously force: state=IDLE, rd_busy=0, out_valid=0, out_last=0, out_err=0, out_data=0x00, count=0, offset=0.
REQ-029 Reset mid-burst shall abandon the burst; no beat of it shall be presented after release.
REQ-030 The first request shall be accepted on the first rising edge after reset=1.

Structure
REQ-031 Shared package gpu_hw_regs_pkg shall hold HW_REGS_SIZE, BASE_ADDRESS and the FSM state enum, shared with the write-side register block.
REQ-032 Sub-module gpu_hw_regs_bytesel shall be combinational and perform window decode (in-range flag, offset) and the byte mux from hw_regs.
REQ-033 The target size is 120-400 lines of RTL total.

Verification
REQ-034 Byte 0x05=0xA7, rd_addr=16133, rd_len=0, out_ready=1 -> out_data=0xA7, out_last=1 and out_err=0 on edge N+2; rd_busy=0 one cycle later.
REQ-035 Bytes 0x10..0x13=01,02,03,04, rd_addr=16144, rd_len=3, out_ready=1 -> four consecutive beats 01,02,03,04 with out_last only on 04.
REQ-036 rd_addr=16383 (offset 255), rd_len=1 -> beats byte255 then byte0, with out_err=0.
REQ-037 rd_addr=0x00010, rd_len=2 -> three beats of 0x00 with out_err=1 and out_last on the third beat.
REQ-038 rd_len=3 with out_ready toggling 1,0,0,1,... -> outputs stable while stalled, and exactly four beats in order.
REQ-039 reset=0 asserted during beat 2 of an 8-beat burst -> all outputs 0 immediately; after release, a new single read returns the correct byte with no stale beats.
